// File: rtl/axi_read_arbiter.sv
// 2:1 AXI read arbiter: round-robin AR grant, burst-locked R routing.
// Optional burst-length checker enabled by AXI_RD_ARB_LEN_CHECK_EN.
module axi_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [LEN_W-1:0]  s0_arlen,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [ID_W-1:0]   s0_rid,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [LEN_W-1:0]  s1_arlen,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [ID_W-1:0]   s1_rid,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [ID_W-1:0]   m_arid,
    output logic [LEN_W-1:0]  m_arlen,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    output logic [1:0]        state,
    output logic              len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } st_e;

    st_e  st_q, st_d;
    logic owner_q, owner_d;
    logic last_q, last_d;

    logic ar_hs;
    logic r_hs;

    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid & m_rready;

    // R payload is shared; only the owner sees rvalid
    assign s0_rdata = m_rdata;
    assign s0_rid   = m_rid;
    assign s0_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rdata = m_rdata;
    assign s1_rid   = m_rid;
    assign s1_rresp = m_rresp;
    assign s1_rlast = m_rlast;

    // busy flag plus owner, owner masked while idle
    assign state = {st_q != IDLE, (st_q != IDLE) & owner_q};

    // state, owner and round-robin history registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q    <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // next-state, grant selection and handshake routing
    always_comb begin
        st_d       = st_q;
        owner_d    = owner_q;
        last_d     = last_q;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        m_araddr   = owner_q ? s1_araddr : s0_araddr;
        m_arid     = owner_q ? s1_arid   : s0_arid;
        m_arlen    = owner_q ? s1_arlen  : s0_arlen;
        unique case (st_q)
            IDLE: begin
                if (s0_arvalid | s1_arvalid) begin
                    st_d = ADDR;
                    if (s0_arvalid & s1_arvalid) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = s1_arvalid;
                    end
                end
            end
            ADDR: begin
                m_arvalid  = 1'b1;
                s0_arready = ~owner_q & m_arready;
                s1_arready = owner_q & m_arready;
                if (m_arready) begin
                    st_d = DATA;
                end
            end
            DATA: begin
                s0_rvalid = ~owner_q & m_rvalid;
                s1_rvalid = owner_q & m_rvalid;
                m_rready  = owner_q ? s1_rready : s0_rready;
                if (m_rvalid & m_rready & m_rlast) begin
                    last_d = owner_q;
                    st_d   = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

`ifdef AXI_RD_ARB_LEN_CHECK_EN
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beat_q;
    logic             err_q;
    logic [LEN_W:0]   beat_nxt;
    logic [LEN_W:0]   beats_exp;

    assign beat_nxt  = beat_q + {{LEN_W{1'b0}}, 1'b1};
    assign beats_exp = {1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1};
    assign len_err   = err_q;

    // count beats and flag rlast placed on the wrong beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (ar_hs) begin
            len_q  <= m_arlen;
            beat_q <= '0;
        end else if ((st_q == DATA) && r_hs) begin
            beat_q <= beat_nxt;
            if (m_rlast != (beat_nxt == beats_exp)) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule
